// File: rtl/count_seq_checker_pkg.sv
// Shared types and helpers for the counter-stream checker.
// Holds the checker state encoding, default thresholds and the step arithmetic.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEFAULT_LOCK_COUNT = 4;
    localparam int DEFAULT_LOSS_COUNT = 2;

    // Callers truncate the result to their own width, which yields modulo-2^WIDTH wrap.
    function automatic logic [31:0] step_val(input logic [31:0] value, input logic down);
        return down ? value - 32'd1 : value + 32'd1;
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Receiving-end checker: verifies each accepted sample is the previous value +/-1,
// acquires lock after a run of good steps and flywheels through isolated glitches.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT,
    parameter int LOSS_COUNT = DEFAULT_LOSS_COUNT,
    parameter int ERR_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic                                sample_valid,
    input  logic [WIDTH-1:0]                    sample_data,
    input  logic                                step_down,
    output logic                                locked,
    output logic                                err_pulse,
    output logic [ERR_W-1:0]                    err_count,
    output logic [WIDTH-1:0]                    expected,
    output logic [$clog2(LOCK_COUNT+1)-1:0]     match_run
);

    localparam int MR_W   = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);
    localparam logic [MR_W-1:0]   LOCK_LAST = MR_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] LOSS_LAST = MISS_W'(LOSS_COUNT - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    expected_d;
    logic [MR_W-1:0]     match_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                err_inc;
    logic                accept;
    logic [WIDTH-1:0]    pred;
    logic                hit;

    assign accept = ena && sample_valid;
    // The check always uses the direction presented with this sample.
    assign pred   = WIDTH'(step_val(32'(prev_q), step_down));
    assign hit    = (sample_data == pred);

    // NOTE: every signal driven here gets its default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        match_d    = match_run;
        miss_d     = miss_q;
        expected_d = expected;
        err_inc    = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    prev_d  = sample_data;
                    match_d = '0;
                    miss_d  = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    prev_d = sample_data;
                    if (!hit) begin
                        match_d = '0;
                    end else if (match_run == LOCK_LAST) begin
                        match_d = '0;
                        state_d = LOCKED;
                    end else begin
                        match_d = match_run + MR_W'(1);
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        miss_d = '0;
                        prev_d = sample_data;
                    end else begin
                        err_inc = 1'b1;
                        if (miss_q == LOSS_LAST) begin
                            state_d = ACQUIRE;
                            prev_d  = sample_data;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            // Flywheel: coast on the prediction so one glitch costs one error.
                            miss_d = miss_q + MISS_W'(1);
                            prev_d = pred;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            expected_d = WIDTH'(step_val(32'(prev_d), step_down));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            expected  <= '0;
            match_run <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            expected  <= expected_d;
            match_run <= match_d;
            miss_q    <= miss_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= err_inc;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus a randomized stream, with two
// parameterisations checked against a behavioural model every cycle.
module tb_count_seq_checker;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       sample_valid = 1'b0;
    logic       step_down = 1'b0;
    logic [7:0] sample_data = 8'd0;

    logic       d_locked, d_err_pulse;
    logic [7:0] d_err_count, d_expected;
    logic [2:0] d_match_run;
    logic       s_locked, s_err_pulse;
    logic [1:0] s_err_count;
    logic [7:0] s_expected;
    logic [2:0] s_match_run;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int mode;
        int prev;
        int expv;
        int match_run;
        int miss_run;
        int err_count;
        int err_pulse;
    } model_t;

    model_t m_main = '{default: 0};
    model_t m_sat  = '{default: 0};

    logic       dir = 1'b0;
    logic       rr, ee, vv, glitch;
    logic [7:0] gen, data;
    int         rate;

    always #5 clk = ~clk;

    count_seq_checker u_dut (
        .clk(clk), .rst(rst), .ena(ena), .sample_valid(sample_valid),
        .sample_data(sample_data), .step_down(step_down),
        .locked(d_locked), .err_pulse(d_err_pulse), .err_count(d_err_count),
        .expected(d_expected), .match_run(d_match_run)
    );

    count_seq_checker #(.LOSS_COUNT(8), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .sample_valid(sample_valid),
        .sample_data(sample_data), .step_down(step_down),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .expected(s_expected), .match_run(s_match_run)
    );

    function automatic model_t model_next(model_t m, int lock_n, int loss_n, int err_max,
                                          logic r, logic e, logic v, logic dn, int d);
        model_t n = m;
        int pred;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.err_pulse = 0;
        if (!(e && v)) return n;
        pred = dn ? (m.prev + 255) % 256 : (m.prev + 1) % 256;
        if (m.mode == M_IDLE) begin
            n.mode = M_ACQ;
            n.prev = d;
            n.match_run = 0;
        end else if (m.mode == M_ACQ) begin
            n.prev = d;
            if (d == pred) begin
                n.match_run = m.match_run + 1;
                if (n.match_run == lock_n) begin
                    n.mode = M_LOCK;
                    n.match_run = 0;
                end
            end else begin
                n.match_run = 0;
            end
        end else begin
            if (d == pred) begin
                n.miss_run = 0;
                n.prev = d;
            end else begin
                n.err_pulse = 1;
                n.err_count = (m.err_count < err_max) ? m.err_count + 1 : err_max;
                n.miss_run = m.miss_run + 1;
                if (n.miss_run == loss_n) begin
                    n.mode = M_ACQ;
                    n.prev = d;
                    n.match_run = 0;
                    n.miss_run = 0;
                end else begin
                    n.prev = pred;
                end
            end
        end
        n.expv = dn ? (n.prev + 255) % 256 : (n.prev + 1) % 256;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("main.locked",    32'(d_locked),    32'(m_main.mode == M_LOCK));
        check("main.err_pulse", 32'(d_err_pulse), 32'(m_main.err_pulse));
        check("main.err_count", 32'(d_err_count), 32'(m_main.err_count));
        check("main.expected",  32'(d_expected),  32'(m_main.expv));
        check("main.match_run", 32'(d_match_run), 32'(m_main.match_run));
        check("sat.locked",     32'(s_locked),    32'(m_sat.mode == M_LOCK));
        check("sat.err_pulse",  32'(s_err_pulse), 32'(m_sat.err_pulse));
        check("sat.err_count",  32'(s_err_count), 32'(m_sat.err_count));
        check("sat.expected",   32'(s_expected),  32'(m_sat.expv));
        check("sat.match_run",  32'(s_match_run), 32'(m_sat.match_run));
    endtask

    task automatic cycle(input logic r, input logic e, input logic v, input logic dn,
                         input logic [7:0] d);
        rst = r; ena = e; sample_valid = v; step_down = dn; sample_data = d;
        @(posedge clk);
        #1;
        m_main = model_next(m_main, 4, 2, 255, r, e, v, dn, int'(d));
        m_sat  = model_next(m_sat,  4, 8, 3,   r, e, v, dn, int'(d));
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b1, dir, 8'd0);
    endtask

    task automatic smp(input logic [7:0] d);
        cycle(1'b0, 1'b1, 1'b1, dir, d);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".locked"},    32'(d_locked),    32'd0);
        check({tag, ".err_pulse"}, 32'(d_err_pulse), 32'd0);
        check({tag, ".err_count"}, 32'(d_err_count), 32'd0);
        check({tag, ".expected"},  32'(d_expected),  32'd0);
        check({tag, ".match_run"}, 32'(d_match_run), 32'd0);
    endtask

    initial begin
        // Reset state
        dir = 1'b0;
        do_reset();
        check_zero("reset");

        // Up lock from 10
        for (int v = 10; v <= 13; v++) smp(8'(v));
        check("uplock.before", 32'(d_locked), 32'd0);
        smp(8'd14);
        check("uplock.locked",   32'(d_locked),    32'd1);
        check("uplock.expected", 32'(d_expected),  32'd15);
        check("uplock.errcnt",   32'(d_err_count), 32'd0);

        // Wrap upward through 255 -> 0
        do_reset();
        for (int v = 253; v <= 257; v++) begin
            smp(8'(v));
            check("wrapup.pulse", 32'(d_err_pulse), 32'd0);
        end
        check("wrapup.locked", 32'(d_locked), 32'd1);

        // Wrap downward through 0 -> 255
        dir = 1'b1;
        do_reset();
        for (int v = 2; v >= -2; v--) begin
            smp(8'(v));
            check("wrapdn.pulse", 32'(d_err_pulse), 32'd0);
        end
        check("wrapdn.locked",   32'(d_locked),   32'd1);
        check("wrapdn.expected", 32'(d_expected), 32'd253);

        // Single glitch while locked at 19
        dir = 1'b0;
        do_reset();
        for (int v = 15; v <= 19; v++) smp(8'(v));
        check("glitch.locked0", 32'(d_locked), 32'd1);
        smp(8'd20);  check("glitch.p20", 32'(d_err_pulse), 32'd0);
        smp(8'd99);  check("glitch.p99", 32'(d_err_pulse), 32'd1);
        smp(8'd22);  check("glitch.p22", 32'(d_err_pulse), 32'd0);
        smp(8'd23);  check("glitch.p23", 32'(d_err_pulse), 32'd0);
        check("glitch.errcnt",   32'(d_err_count), 32'd1);
        check("glitch.locked",   32'(d_locked),    32'd1);
        check("glitch.expected", 32'(d_expected),  32'd24);

        // Loss of lock and re-acquisition
        do_reset();
        for (int v = 45; v <= 49; v++) smp(8'(v));
        smp(8'd77);  check("loss.p77", 32'(d_err_pulse), 32'd1);
        check("loss.stay", 32'(d_locked), 32'd1);
        smp(8'd88);  check("loss.p88", 32'(d_err_pulse), 32'd1);
        check("loss.errcnt", 32'(d_err_count), 32'd2);
        check("loss.unlock", 32'(d_locked),    32'd0);
        for (int v = 89; v <= 91; v++) smp(8'(v));
        check("loss.notyet", 32'(d_locked), 32'd0);
        smp(8'd92);
        check("loss.relock", 32'(d_locked), 32'd1);

        // Acquire mismatch and ena gating
        do_reset();
        smp(8'd5);   check("acq.mr5",  32'(d_match_run), 32'd0);
        smp(8'd6);   check("acq.mr6",  32'(d_match_run), 32'd1);
        smp(8'd40);  check("acq.mr40", 32'(d_match_run), 32'd0);
        check("acq.pulse", 32'(d_err_pulse), 32'd0);
        smp(8'd41);  check("acq.mr41", 32'(d_match_run), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, dir, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, dir, 8'd0);
        check("ena.hold_mr",  32'(d_match_run), 32'd1);
        check("ena.hold_exp", 32'(d_expected),  32'd42);
        smp(8'd42);
        smp(8'd43);
        check("ena.mr3", 32'(d_match_run), 32'd3);
        smp(8'd44);
        check("ena.locked", 32'(d_locked), 32'd1);

        // Saturation on the narrow counter, then reset alongside a valid sample
        do_reset();
        for (int v = 10; v <= 14; v++) smp(8'(v));
        for (int k = 0; k < 5; k++) smp(8'd200);
        check("sat.errcnt", 32'(s_err_count), 32'd3);
        check("sat.locked", 32'(s_locked),    32'd1);
        cycle(1'b1, 1'b1, 1'b1, dir, 8'd77);
        check_zero("rstmid");
        check("rstmid.sat_locked", 32'(s_locked),    32'd0);
        check("rstmid.sat_errcnt", 32'(s_err_count), 32'd0);

        // Randomized stream with varying glitch density
        gen = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 500) % 3 == 0) ? 50 : (((i / 500) % 3 == 1) ? 6 : 2);
            rr = ($urandom_range(0, 299) == 0);
            ee = ($urandom_range(0, 7) != 0);
            vv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            if (ee && vv && !rr) gen = dir ? gen - 8'd1 : gen + 8'd1;
            glitch = ($urandom_range(0, rate - 1) == 0);
            data = glitch ? 8'($urandom) : gen;
            cycle(rr, ee, vv, dir, data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
